// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory access controller.
//   size_t  - request size encoding (byte / half / word / illegal)
//   state_t - controller FSM states
//   size_addr_legal - alignment/size legality check at acceptance
//   size_last_idx   - index of the final byte access for a size
//   extend_load     - sign/zero extension of assembled load data
package dmem_pkg;

  localparam int NUM_REQ    = 2;
  localparam int REQ_CORE   = 0;
  localparam int REQ_LOADER = 1;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_t;

  typedef enum logic [2:0] {
    IDLE,
    ERR,
    ACCESS,
    DRAIN,
    RESP
  } state_t;

  // Halves need even addresses, words need 4-byte alignment, 2'b11 is never legal.
  function automatic logic size_addr_legal(size_t size, logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~addr_lo[0];
      SZ_WORD: return (addr_lo == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] size_last_idx(size_t size);
    case (size)
      SZ_BYTE: return 2'd0;
      SZ_HALF: return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(size_t size, logic uns, logic [31:0] raw);
    case (size)
      SZ_BYTE: return uns ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      SZ_HALF: return uns ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin arbiter.
//   clk, rst_n - clock and asynchronous active-low reset
//   req        - request vector
//   update     - strobe: the current grant is being consumed, remember it
//   gnt        - one-hot grant (zero when nothing requests)
//   gnt_idx    - index of the granted requester
// The pointer holds the last granted index; it resets to 1 so requester 0
// wins the first tie.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  logic last_q, last_d;

  // On a tie pick the requester that was not granted last.
  always_comb begin
    gnt_idx = req[1] & (~req[0] | ~last_q);
    gnt     = (req == 2'b00) ? 2'b00 : (gnt_idx ? 2'b10 : 2'b01);
    last_d  = update ? gnt_idx : last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: multicycle arbiter/controller in front of a byte-wide RAM.
//   clk, rst_n          - clock and asynchronous active-low reset
//   req_*               - two requesters (0 = core LSU, 1 = loader)
//   req_ready           - combinational accept pulse, IDLE cycle only
//   rsp_valid/err/rdata - registered one-cycle response to the owner
//   mem_addr/we/wdata   - registered RAM byte interface
//   mem_rdata           - RAM read byte, valid the cycle after mem_addr
// Each request becomes 1/2/4 sequential byte accesses, little-endian.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [1:0]                 req_we,
  input  logic [1:0][1:0]            req_size,
  input  logic [1:0]                 req_uns,
  input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0][DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]                 rsp_valid,
  output logic                       rsp_err,
  output logic [DATA_WIDTH-1:0]      rsp_rdata,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic                       mem_we,
  output logic [7:0]                 mem_wdata,
  input  logic [7:0]                 mem_rdata
);

  state_t                  state_q, state_d;
  logic                    we_q, we_d;
  size_t                   size_q, size_d;
  logic                    uns_q, uns_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    owner_q, owner_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   asm_q, asm_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic                    mem_we_q, mem_we_d;
  logic [7:0]              mem_wdata_q, mem_wdata_d;
  logic [1:0]              rsp_valid_q, rsp_valid_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic       gnt_idx;
  logic [1:0] gnt_oh;
  logic       arb_update;
  size_t      sel_size;
  logic       sel_legal;
  logic [1:0] prev_idx;

  assign arb_update = (state_q == IDLE) && (|req_valid);
  assign sel_size   = size_t'(req_size[gnt_idx]);
  assign sel_legal  = size_addr_legal(sel_size, req_addr[gnt_idx][1:0]);
  assign prev_idx   = cnt_q - 2'd1;

  rr_arbiter_2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .update  (arb_update),
    .gnt     (gnt_oh),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = (state_q == IDLE) ? gnt_oh : 2'b00;

  // Next-state logic. Response outputs and mem_we default to 0 so they only
  // pulse where explicitly set. During a load, the byte addressed in the
  // previous ACCESS cycle is on mem_rdata, so ACCESS captures byte cnt-1 and
  // DRAIN captures the final byte.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 2'b00;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;

    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          we_d    = req_we[gnt_idx];
          size_d  = sel_size;
          uns_d   = req_uns[gnt_idx];
          wdata_d = req_wdata[gnt_idx];
          owner_d = gnt_idx;
          cnt_d   = 2'd0;
          asm_d   = '0;
          if (sel_legal) begin
            state_d     = ACCESS;
            mem_addr_d  = req_addr[gnt_idx];
            mem_we_d    = req_we[gnt_idx];
            mem_wdata_d = req_wdata[gnt_idx][7:0];
          end else begin
            state_d              = ERR;
            rsp_valid_d[gnt_idx] = 1'b1;
            rsp_err_d            = 1'b1;
          end
        end
      end
      ERR: begin
        state_d = IDLE;
      end
      ACCESS: begin
        if (!we_q && (cnt_q != 2'd0)) begin
          asm_d[{prev_idx, 3'b000} +: 8] = mem_rdata;
        end
        if (cnt_q != size_last_idx(size_q)) begin
          cnt_d       = cnt_q + 2'd1;
          mem_addr_d  = mem_addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          mem_we_d    = we_q;
          mem_wdata_d = wdata_q[{cnt_d, 3'b000} +: 8];
        end else if (we_q) begin
          state_d              = RESP;
          rsp_valid_d[owner_q] = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        asm_d[{cnt_q, 3'b000} +: 8] = mem_rdata;
        state_d              = RESP;
        rsp_valid_d[owner_q] = 1'b1;
        rsp_rdata_d          = extend_load(size_q, uns_q, asm_d);
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state and registered outputs; reset aborts any access in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
      owner_q     <= 1'b0;
      cnt_q       <= 2'd0;
      asm_q       <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 8'h00;
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Testbench for dmem_access_ctrl with a behavioural byte RAM.
module tb_dmem_access_ctrl;

   logic              clk;
   logic              rst_n;
   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [1:0]        req_we;
   logic [1:0][1:0]   req_size;
   logic [1:0]        req_uns;
   logic [1:0][16:0]  req_addr;
   logic [1:0][31:0]  req_wdata;
   logic [1:0]        rsp_valid;
   logic              rsp_err;
   logic [31:0]       rsp_rdata;
   logic [16:0]       mem_addr;
   logic              mem_we;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;

   logic [7:0]        ram [0:(1<<17)-1];

   int checkCount = 0;
   int failCount  = 0;

   dmem_access_ctrl #(.ADDR_WIDTH(17), .DATA_WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_size  (req_size),
      .req_uns   (req_uns),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_err   (rsp_err),
      .rsp_rdata (rsp_rdata),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Byte RAM with a registered read port, matching the one-cycle read latency.
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Issue one request from requester idx in an IDLE cycle, then follow it
   // to its response, checking store beats, latency and the response fields.
   task automatic applyStimulus(input int idx, input logic we, input logic [1:0] size,
                                input logic uns, input logic [16:0] addr, input logic [31:0] wdata,
                                input int expLat, input logic expErr, input logic [31:0] expData,
                                input int expWe);
      int lat;
      int nWe;
      bit seen;
      logic [31:0] wsh;
      lat  = 0;
      nWe  = 0;
      seen = 0;
      @(negedge clk);
      req_valid      = 2'b00;
      req_valid[idx] = 1'b1;
      req_we[idx]    = we;
      req_size[idx]  = size;
      req_uns[idx]   = uns;
      req_addr[idx]  = addr;
      req_wdata[idx] = wdata;
      #1;
      checkOutput("ready", {30'b0, req_ready}, 32'(1 << idx));
      while (!seen && lat < 20) begin
         @(negedge clk);
         req_valid = 2'b00;
         lat++;
         #1;
         if (mem_we) begin
            wsh = wdata >> (8 * nWe);
            checkOutput("st_addr", {15'b0, mem_addr}, {15'b0, addr} + nWe);
            checkOutput("st_data", {24'b0, mem_wdata}, {24'b0, wsh[7:0]});
            nWe++;
         end
         if (rsp_valid != 2'b00) seen = 1;
      end
      if (!seen) begin
         checkOutput("rsp_timeout", 32'd0, 32'd1);
      end else begin
         checkOutput("latency", lat, expLat);
         checkOutput("rsp_who", {30'b0, rsp_valid}, 32'(1 << idx));
         checkOutput("rsp_err", {31'b0, rsp_err}, {31'b0, expErr});
         checkOutput("rsp_data", rsp_rdata, expData);
         checkOutput("we_cycles", nWe, expWe);
         @(negedge clk);
         #1;
         checkOutput("rsp_pulse", {30'b0, rsp_valid}, 32'd0);
      end
   endtask

   task automatic doReset();
      req_valid = 2'b00;
      rst_n     = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Main directed sequence.
   initial begin
      int grants;
      int rsps;
      int cyc;
      logic [1:0] lastGrant;
      logic [1:0] prevReady;

      req_valid = 2'b00;
      req_we    = '0;
      req_size  = '0;
      req_uns   = '0;
      req_addr  = '0;
      req_wdata = '0;
      rst_n     = 1'b0;
      #12;
      checkOutput("rst_ready", {30'b0, req_ready}, 32'd0);
      checkOutput("rst_rsp_valid", {30'b0, rsp_valid}, 32'd0);
      checkOutput("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
      checkOutput("rst_rdata", rsp_rdata, 32'd0);
      checkOutput("rst_mem_we", {31'b0, mem_we}, 32'd0);
      checkOutput("rst_mem_addr", {15'b0, mem_addr}, 32'd0);
      checkOutput("rst_mem_wdata", {24'b0, mem_wdata}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Word store and its byte layout in RAM.
      applyStimulus(0, 1'b1, 2'b10, 1'b0, 17'h00010, 32'hDEADBEEF, 5, 1'b0, 32'h0, 4);
      checkOutput("ram_10", {24'b0, ram[17'h10]}, 32'hEF);
      checkOutput("ram_11", {24'b0, ram[17'h11]}, 32'hBE);
      checkOutput("ram_12", {24'b0, ram[17'h12]}, 32'hAD);
      checkOutput("ram_13", {24'b0, ram[17'h13]}, 32'hDE);

      // Loader preloads two bytes, core reads them back as a half.
      applyStimulus(1, 1'b1, 2'b00, 1'b0, 17'h00020, 32'h00000080, 2, 1'b0, 32'h0, 1);
      applyStimulus(1, 1'b1, 2'b00, 1'b0, 17'h00021, 32'h000000FF, 2, 1'b0, 32'h0, 1);
      applyStimulus(0, 1'b0, 2'b01, 1'b0, 17'h00020, 32'h0, 4, 1'b0, 32'hFFFFFF80, 0);
      applyStimulus(0, 1'b0, 2'b01, 1'b1, 17'h00020, 32'h0, 4, 1'b0, 32'h0000FF80, 0);

      // Byte and word loads over the first store.
      applyStimulus(0, 1'b0, 2'b00, 1'b0, 17'h00013, 32'h0, 3, 1'b0, 32'hFFFFFFDE, 0);
      applyStimulus(0, 1'b0, 2'b00, 1'b1, 17'h00013, 32'h0, 3, 1'b0, 32'h000000DE, 0);
      applyStimulus(0, 1'b0, 2'b10, 1'b1, 17'h00010, 32'h0, 6, 1'b0, 32'hDEADBEEF, 0);

      // Illegal requests: misaligned word, size 11, odd half.
      applyStimulus(0, 1'b0, 2'b10, 1'b0, 17'h00012, 32'h0, 1, 1'b1, 32'h0, 0);
      applyStimulus(0, 1'b1, 2'b11, 1'b0, 17'h00000, 32'h12345678, 1, 1'b1, 32'h0, 0);
      applyStimulus(1, 1'b0, 2'b01, 1'b0, 17'h00021, 32'h0, 1, 1'b1, 32'h0, 0);
      checkOutput("ram_00_untouched", {24'b0, ram[17'h00] === 8'h78 ? 8'h01 : 8'h00}, 32'h0);

      // Both requesters hold byte stores after reset; grants must alternate.
      doReset();
      @(negedge clk);
      req_we    = 2'b11;
      req_size  = '0;
      req_uns   = 2'b00;
      req_addr[0]  = 17'h00050;
      req_addr[1]  = 17'h00060;
      req_wdata[0] = 32'h000000A5;
      req_wdata[1] = 32'h0000005A;
      req_valid = 2'b11;
      grants    = 0;
      rsps      = 0;
      cyc       = 0;
      lastGrant = 2'b00;
      prevReady = 2'b00;
      #1;
      while (rsps < 4 && cyc < 60) begin
         if (prevReady != 2'b00) checkOutput("ready_pulse", {30'b0, req_ready}, 32'd0);
         if (req_ready != 2'b00) begin
            checkOutput("rr_grant", {30'b0, req_ready}, (grants % 2 == 1) ? 32'd2 : 32'd1);
            lastGrant = req_ready;
            grants++;
         end
         if (rsp_valid != 2'b00) begin
            checkOutput("rr_rsp", {30'b0, rsp_valid}, {30'b0, lastGrant});
            rsps++;
         end
         prevReady = req_ready;
         @(negedge clk);
         if (grants >= 4) req_valid = 2'b00;
         cyc++;
         #1;
      end
      checkOutput("rr_rsp_count", rsps, 32'd4);
      checkOutput("ram_50", {24'b0, ram[17'h50]}, 32'hA5);
      checkOutput("ram_60", {24'b0, ram[17'h60]}, 32'h5A);

      // Reset during the third byte of a word store.
      applyStimulus(0, 1'b1, 2'b10, 1'b0, 17'h00040, 32'h11223344, 5, 1'b0, 32'h0, 4);
      @(negedge clk);
      req_valid    = 2'b01;
      req_we[0]    = 1'b1;
      req_size[0]  = 2'b10;
      req_addr[0]  = 17'h00040;
      req_wdata[0] = 32'hAABBCCDD;
      #1;
      checkOutput("abort_ready", {30'b0, req_ready}, 32'd1);
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      @(negedge clk);
      #1;
      checkOutput("abort_byte2_we", {31'b0, mem_we}, 32'd1);
      checkOutput("abort_byte2_addr", {15'b0, mem_addr}, 32'h42);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_we_drop", {31'b0, mem_we}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         checkOutput("abort_no_rsp", {30'b0, rsp_valid}, 32'd0);
         checkOutput("abort_no_we", {31'b0, mem_we}, 32'd0);
      end
      checkOutput("abort_ram_40", {24'b0, ram[17'h40]}, 32'hDD);
      checkOutput("abort_ram_41", {24'b0, ram[17'h41]}, 32'hCC);
      checkOutput("abort_ram_42", {24'b0, ram[17'h42]}, 32'h22);
      checkOutput("abort_ram_43", {24'b0, ram[17'h43]}, 32'h11);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(0, 1'b0, 2'b10, 1'b0, 17'h00040, 32'h0, 6, 1'b0, 32'h1122CCDD, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
